// File: rtl/imem_arbiter_pkg.sv
// ============================================================================
// Module   : imem_arbiter_pkg
// Purpose  : Shared types and constants for the instruction memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DEBUG = 2'd2
    } owner_t;

    localparam logic [31:0] c_nop            = 32'h0000_0013;
    localparam int          c_addr_w_default = 8;

endpackage

`default_nettype wire

// File: rtl/imem_addr_check.sv
// ============================================================================
// Module   : imem_addr_check
// Purpose  : Byte-address decode: misalignment/range error and word address.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_addr_check
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_default
) (
    input  logic [31:0]       addr,
    output logic              err,
    output logic [ADDR_W-1:0] word
);

    logic w_misalign;
    logic w_out_of_range;

    assign w_misalign = |addr[1:0];
    assign word       = addr[ADDR_W+1:2];

    // Any set bit above the word-address field lands past the memory.
    generate
        if (ADDR_W < 30) begin : g_range
            assign w_out_of_range = |addr[31:ADDR_W+2];
        end else begin : g_full
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign err = w_misalign | w_out_of_range;

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Two-port (fetch/debug) read arbiter in front of a 1-cycle memory.
//            Define IMEM_STARVE_GUARD_EN to bound debug starvation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = c_addr_w_default,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              f_req_valid,
    input  logic [31:0]       f_addr,
    output logic              f_req_ready,
    output logic              f_rsp_valid,
    output logic [31:0]       f_rsp_data,
    output logic              f_rsp_err,
    input  logic              flush,
    input  logic              d_req_valid,
    input  logic [31:0]       d_addr,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_q
);

    logic              w_f_err;
    logic              w_d_err;
    logic [ADDR_W-1:0] w_f_word;
    logic [ADDR_W-1:0] w_d_word;
    logic              w_force_debug;
    logic [31:0]       w_rsp_word;
    owner_t            r_owner;
    logic              r_err;
    logic [31:0]       r_f_hold;
    logic [31:0]       r_d_hold;

    imem_addr_check #(.ADDR_W(ADDR_W)) u_f_check (
        .addr (f_addr),
        .err  (w_f_err),
        .word (w_f_word)
    );

    imem_addr_check #(.ADDR_W(ADDR_W)) u_d_check (
        .addr (d_addr),
        .err  (w_d_err),
        .word (w_d_word)
    );

`ifdef IMEM_STARVE_GUARD_EN
    localparam int                c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_starve_cnt;

    // Counts fetch wins only while debug is actually waiting.
    always_ff @(posedge clock) begin
        if (rst || !d_req_valid || d_req_ready) begin
            r_starve_cnt <= '0;
        end else if (f_req_ready) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_force_debug = d_req_valid && (r_starve_cnt >= c_limit);
`else
    logic w_unused_limit;
    assign w_unused_limit = (STARVE_LIMIT > 0);
    assign w_force_debug  = 1'b0;
`endif

    assign f_req_ready = !rst && f_req_valid && !flush && !w_force_debug;
    assign d_req_ready = !rst && d_req_valid && !f_req_ready;

    // Illegal addresses are still granted, but never touch the memory.
    assign mem_rd_en = (f_req_ready && !w_f_err) || (d_req_ready && !w_d_err);
    assign mem_addr  = f_req_ready ? w_f_word :
                       d_req_ready ? w_d_word : '0;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_owner <= OWN_NONE;
            r_err   <= 1'b0;
        end else if (f_req_ready) begin
            r_owner <= OWN_FETCH;
            r_err   <= w_f_err;
        end else if (d_req_ready) begin
            r_owner <= OWN_DEBUG;
            r_err   <= w_d_err;
        end else begin
            r_owner <= OWN_NONE;
            r_err   <= 1'b0;
        end
    end

    assign w_rsp_word  = r_err ? c_nop : mem_q;
    assign f_rsp_valid = !rst && (r_owner == OWN_FETCH) && !flush;
    assign d_rsp_valid = !rst && (r_owner == OWN_DEBUG);
    assign f_rsp_err   = f_rsp_valid && r_err;
    assign d_rsp_err   = d_rsp_valid && r_err;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_f_hold <= '0;
            r_d_hold <= '0;
        end else begin
            if (f_rsp_valid) r_f_hold <= w_rsp_word;
            if (d_rsp_valid) r_d_hold <= w_rsp_word;
        end
    end

    assign f_rsp_data = rst ? 32'h0 : (f_rsp_valid ? w_rsp_word : r_f_hold);
    assign d_rsp_data = rst ? 32'h0 : (d_rsp_valid ? w_rsp_word : r_d_hold);

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Scoreboard bench for imem_arbiter (directed + random traffic).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_arbiter;

    localparam int          ADDR_W       = 8;
    localparam int          STARVE_LIMIT = 4;
    localparam logic [31:0] NOP          = 32'h0000_0013;
`ifdef IMEM_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic              f_req_valid = 1'b0, d_req_valid = 1'b0, flush = 1'b0;
    logic [31:0]       f_addr = '0, d_addr = '0, mem_q = '0;
    logic              f_req_ready, f_rsp_valid, f_rsp_err;
    logic              d_req_ready, d_rsp_valid, d_rsp_err, mem_rd_en;
    logic [31:0]       f_rsp_data, d_rsp_data;
    logic [ADDR_W-1:0] mem_addr;

    imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock), .rst(rst),
        .f_req_valid(f_req_valid), .f_addr(f_addr), .f_req_ready(f_req_ready),
        .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
        .flush(flush),
        .d_req_valid(d_req_valid), .d_addr(d_addr), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [256];

    // Memory answers the cycle after a strobe; otherwise garbage on the bus.
    always @(posedge clock) mem_q <= mem_rd_en ? mem[mem_addr] : $urandom;

    typedef struct {
        int          cyc;
        bit          is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0, cyc = 0;
    bit          exp_f_ready, exp_d_ready, exp_rd;
    logic [31:0] exp_addr;
    bit          pend_v = 0;
    exp_t        pend;
    int          starve = 0;
    logic [31:0] last_f = '0, last_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * (1 << ADDR_W)));
    endfunction

    function automatic logic [31:0] rand_addr();
        int k = $urandom_range(0, 9);
        logic [31:0] a = 32'($urandom_range(0, 255)) << 2;
        if (k == 7) a = a | 32'($urandom_range(1, 3));
        else if (k == 8) a = 32'h400 + (32'($urandom_range(0, 255)) << 2);
        else if (k == 9) a = $urandom;
        return a;
    endfunction

    // One clock of stimulus; the reference model decides grants and responses.
    task automatic step(input bit fv, input logic [31:0] fa, input bit dv,
                        input logic [31:0] da, input bit fl, input bit r);
        int g;
        logic [31:0] a;
        @(posedge clock);
        #1;
        cyc++;
        rst = r; f_req_valid = fv; f_addr = fa; d_req_valid = dv; d_addr = da; flush = fl;
        if (pend_v && !r && !(!pend.is_d && fl)) begin
            pend.cyc = cyc;
            q.push_back(pend);
        end
        pend_v = 0;
        g = 0;
        if (!r) begin
            if (fv && !fl && !(GUARD && dv && starve >= STARVE_LIMIT)) g = 1;
            else if (dv) g = 2;
        end
        exp_f_ready = (g == 1);
        exp_d_ready = (g == 2);
        exp_rd = 0;
        exp_addr = '0;
        if (g != 0) begin
            a = (g == 1) ? fa : da;
            pend.is_d = (g == 2);
            pend.err  = addr_bad(a);
            pend.data = pend.err ? NOP : mem[a[ADDR_W+1:2]];
            pend_v = 1;
            exp_rd = !pend.err;
            exp_addr = 32'(a[ADDR_W+1:2]);
        end
        if (r || !dv || g == 2) starve = 0;
        else if (g == 1) starve++;
    endtask

    always @(negedge clock) begin
        if (cyc > 0) begin
            exp_t e;
            if (rst) begin
                last_f = '0;
                last_d = '0;
                chk("mem_addr_rst", 32'(mem_addr), 32'h0);
            end
            chk("f_req_ready", 32'(f_req_ready), 32'(exp_f_ready));
            chk("d_req_ready", 32'(d_req_ready), 32'(exp_d_ready));
            chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
            if (exp_rd) chk("mem_addr", 32'(mem_addr), exp_addr);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("rsp_missing", 32'(e.cyc), 32'(cyc));
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                if (e.is_d) begin
                    chk("d_rsp_valid", 32'(d_rsp_valid), 32'h1);
                    chk("f_rsp_valid_idle", 32'(f_rsp_valid), 32'h0);
                    chk("d_rsp_data", d_rsp_data, e.data);
                    chk("d_rsp_err", 32'(d_rsp_err), 32'(e.err));
                    chk("f_rsp_hold", f_rsp_data, last_f);
                    last_d = e.data;
                end else begin
                    chk("f_rsp_valid", 32'(f_rsp_valid), 32'h1);
                    chk("d_rsp_valid_idle", 32'(d_rsp_valid), 32'h0);
                    chk("f_rsp_data", f_rsp_data, e.data);
                    chk("f_rsp_err", 32'(f_rsp_err), 32'(e.err));
                    chk("d_rsp_hold", d_rsp_data, last_d);
                    last_f = e.data;
                end
            end else begin
                chk("f_rsp_valid_idle", 32'(f_rsp_valid), 32'h0);
                chk("d_rsp_valid_idle", 32'(d_rsp_valid), 32'h0);
                chk("f_rsp_err_idle", 32'(f_rsp_err), 32'h0);
                chk("d_rsp_err_idle", 32'(d_rsp_err), 32'h0);
                chk("f_rsp_hold", f_rsp_data, last_f);
                chk("d_rsp_hold", d_rsp_data, last_d);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[1] = 32'hDEAD_BEEF;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h04, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'h08, 1, 32'h0C, 0, 0);
        step(0, 0, 1, 32'h0C, 0, 0);
        step(1, 32'h402, 0, 0, 0, 0);
        step(1, 32'h400, 0, 0, 0, 0);
        step(1, 32'h10, 0, 0, 0, 0);
        step(1, 32'h14, 1, 32'h18, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 32'(i) << 2, 1, 32'h80, 0, 0);
        step(1, 32'h20, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h24, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0,
                 rand_addr(), $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
